// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM encoding,
// the default NOP word and the index-width helper.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Word-index width for a memory of the given depth.
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage : cpu_mem_pkg

// File: rtl/imem_byte_assembler.sv
// Packs a byte stream into 32-bit words; the completed word is presented
// combinationally alongside the 4th byte so it can be written in that clock.
module imem_byte_assembler #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  input  logic        strobe,
  output logic [31:0] word_c,
  output logic        word_valid_c
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_c       = BIG_ENDIAN ? {shift_q, in_byte} : {in_byte, shift_q};
    word_valid_c = 1'b0;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (strobe) begin
      shift_d      = BIG_ENDIAN ? word_c[23:0] : word_c[31:8];
      cnt_d        = cnt_q + 2'd1;
      word_valid_c = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : imem_byte_assembler

// File: rtl/prog_instruction_memory.sv
// Loadable instruction memory: registered CPU fetch with range/alignment
// checking, plus a byte-serial program load port fed by the boot receiver.
module prog_instruction_memory
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 31,
  parameter logic [31:0] NOP_WORD   = cpu_mem_pkg::NOP_WORD,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       Address,
  input  logic                    fetch_en,
  output logic [31:0]             Instruction,
  output logic                    instr_valid,
  output logic                    fetch_fault,
  input  logic                    load_start,
  input  logic [7:0]              load_byte,
  input  logic                    load_byte_valid,
  input  logic [idx_w(DEPTH):0]   load_len,
  output logic                    busy,
  output logic                    load_done
);

  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam int unsigned LEN_W = IDX_W + 1;

  logic [31:0] mem_q [DEPTH] = '{default: NOP_WORD};

  imem_state_e state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wptr_q, wptr_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_valid_q, instr_valid_d;
  logic             fetch_fault_q, fetch_fault_d;
  logic             busy_q, busy_d;
  logic             load_done_q, load_done_d;

  logic             asm_clear;
  logic             asm_strobe;
  logic [31:0]      asm_word_c;
  logic             asm_valid_c;
  logic             mem_we;

  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_oor;
  logic             fetch_mis;
  logic             len_ok;

  assign fetch_idx  = Address[IDX_W+1:2];
  assign fetch_oor  = |(Address >> (IDX_W + 2));
  assign fetch_mis  = |Address[1:0];
  assign len_ok     = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
  assign asm_strobe = load_byte_valid && (state_q == LOAD);

  imem_byte_assembler #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .clk          (clk),
    .reset        (reset),
    .clear        (asm_clear),
    .in_byte      (load_byte),
    .strobe       (asm_strobe),
    .word_c       (asm_word_c),
    .word_valid_c (asm_valid_c)
  );

  // Load sequencing and fetch response.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    wptr_d        = wptr_q;
    asm_clear     = 1'b0;
    mem_we        = 1'b0;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    fetch_fault_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (load_start && len_ok) begin
          state_d   = LOAD;
          len_d     = load_len;
          wptr_d    = '0;
          asm_clear = 1'b1;
        end
      end
      LOAD: begin
        if (asm_valid_c) begin
          mem_we = 1'b1;
          wptr_d = wptr_q + LEN_W'(1);
          if (wptr_d == len_q) state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase

    // Fetches while loading are suppressed; the CPU is expected to stall on busy.
    if (fetch_en) begin
      if (state_q == LOAD) begin
        instr_d = NOP_WORD;
      end else if (fetch_oor || fetch_mis) begin
        instr_d       = NOP_WORD;
        fetch_fault_d = 1'b1;
      end else begin
        instr_d       = mem_q[fetch_idx];
        instr_valid_d = 1'b1;
      end
    end

    busy_d      = (state_d == LOAD);
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      len_q         <= '0;
      wptr_q        <= '0;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      busy_q        <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      wptr_q        <= wptr_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fetch_fault_q <= fetch_fault_d;
      busy_q        <= busy_d;
      load_done_q   <= load_done_d;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[wptr_q[IDX_W-1:0]] <= asm_word_c;
  end

  assign Instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign busy        = busy_q;
  assign load_done   = load_done_q;

endmodule : prog_instruction_memory
